// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search: launch core per candidate, scan decrypted RAM for lowercase/space text.
// Core launch is a four-phase start/finished handshake; each checked byte costs two cycles (read + check).
module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH = 24,
  parameter int                   MSG_LEN   = 32,
  parameter logic [KEY_WIDTH-1:0] KEY_START = KEY_WIDTH'(24'h000000),
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 search_start,
  input  logic                 arcfour_finished,
  input  logic [7:0]           dec_data,
  output logic                 start_sig,
  output logic [KEY_WIDTH-1:0] key,
  output logic [7:0]           dec_address,
  output logic                 key_found,
  output logic                 key_fail,
  output logic                 search_done,
  output logic [3:0]           state_tap
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LAUNCH    = 4'd1,
    S_WAIT_DONE = 4'd2,
    S_RELEASE   = 4'd3,
    S_READ      = 4'd4,
    S_CHECK     = 4'd5,
    S_NEXT_KEY  = 4'd6,
    S_FOUND     = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

  localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);

  state_t                 state, state_nxt;
  logic [KEY_WIDTH-1:0]   key_nxt;
  logic [7:0]             addr_nxt;
  logic                   byte_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      key         <= KEY_START;
      dec_address <= 8'd0;
    end else begin
      state       <= state_nxt;
      key         <= key_nxt;
      dec_address <= addr_nxt;
    end
  end

  assign byte_ok = ((dec_data >= 8'h61) && (dec_data <= 8'h7A)) || (dec_data == 8'h20);

  always_comb begin
    state_nxt = state;
    key_nxt   = key;
    addr_nxt  = dec_address;
    case (state)
      S_IDLE:      if (search_start) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (arcfour_finished) state_nxt = S_RELEASE;
      // A finished flag left high from a previous run must still go low before reading.
      S_RELEASE: begin
        if (!arcfour_finished) begin
          addr_nxt  = 8'd0;
          state_nxt = S_READ;
        end
      end
      S_READ:      state_nxt = S_CHECK;
      S_CHECK: begin
        if (!byte_ok) begin
          state_nxt = S_NEXT_KEY;
        end else if (dec_address == LAST_ADDR) begin
          state_nxt = S_FOUND;
        end else begin
          addr_nxt  = dec_address + 8'd1;
          state_nxt = S_READ;
        end
      end
      S_NEXT_KEY: begin
        if (key == KEY_MAX) begin
          state_nxt = S_FAIL;
        end else begin
          key_nxt   = key + 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_FOUND:     state_nxt = S_FOUND;
      S_FAIL:      state_nxt = S_FAIL;
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign start_sig   = (state == S_LAUNCH) || (state == S_WAIT_DONE);
  assign key_found   = (state == S_FOUND);
  assign key_fail    = (state == S_FAIL);
  assign search_done = key_found | key_fail;
  assign state_tap   = state;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench: two controller instances (full key range, and KEY_MAX=3) driven by a core/RAM stub.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        ss_a = 1'b0, ss_b = 1'b0;
  logic        fin_a = 1'b0, fin_b = 1'b0;
  logic [7:0]  dd_a = 8'h00, dd_b = 8'h00;
  logic        start_a, start_b, found_a, found_b, fail_a, fail_b, done_a, done_b;
  logic [23:0] key_a, key_b;
  logic [7:0]  addr_a, addr_b;
  logic [3:0]  tap_a, tap_b;

  rc4_key_search_ctrl dut_a (
    .clk(clk), .reset(reset), .search_start(ss_a), .arcfour_finished(fin_a),
    .dec_data(dd_a), .start_sig(start_a), .key(key_a), .dec_address(addr_a),
    .key_found(found_a), .key_fail(fail_a), .search_done(done_a), .state_tap(tap_a)
  );

  rc4_key_search_ctrl #(.KEY_MAX(24'h000003)) dut_b (
    .clk(clk), .reset(reset), .search_start(ss_b), .arcfour_finished(fin_b),
    .dec_data(dd_b), .start_sig(start_b), .key(key_b), .dec_address(addr_b),
    .key_found(found_b), .key_fail(fail_b), .search_done(done_b), .state_tap(tap_b)
  );

  int   mode = 0;
  logic cur = 1'b0;
  logic stuck_a = 1'b0;
  logic clr = 1'b0;
  int   cnt_a = 0, cnt_b = 0;

  logic        st_c, found_c, fail_c, done_c;
  logic [23:0] key_c;
  logic [7:0]  addr_c;
  logic [3:0]  tap_c;
  assign st_c    = cur ? start_b : start_a;
  assign found_c = cur ? found_b : found_a;
  assign fail_c  = cur ? fail_b  : fail_a;
  assign done_c  = cur ? done_b  : done_a;
  assign key_c   = cur ? key_b   : key_a;
  assign addr_c  = cur ? addr_b  : addr_a;
  assign tap_c   = cur ? tap_b   : tap_a;

  function automatic logic [7:0] ram(input int m, input logic [23:0] k, input logic [7:0] a);
    case (m)
      2: return (k < 24'd3 && a == 8'd5) ? 8'h41 : 8'h7A;
      3: return 8'h7B;
      4: begin
        if (a != 8'd31) return 8'h61;
        case (k)
          24'd0:   return 8'h60;
          24'd1:   return 8'h7B;
          24'd2:   return 8'h20;
          default: return 8'h7A;
        endcase
      end
      default: return 8'h61;
    endcase
  endfunction

  int          launches = 0, keychg_bad = 0, byte6 = 0, reads = 0, idle_bad = 0, maxaddr = 0;
  logic        prev_st = 1'b0;
  logic [23:0] prev_key = 24'h0;

  // Core stub: finished rises 20 cycles into start_sig, falls once start_sig drops.
  always @(negedge clk) begin
    if (stuck_a) fin_a = 1'b1;
    else if (!start_a) begin fin_a = 1'b0; cnt_a = 0; end
    else if (!fin_a) begin cnt_a++; if (cnt_a >= 20) fin_a = 1'b1; end
    if (!start_b) begin fin_b = 1'b0; cnt_b = 0; end
    else if (!fin_b) begin cnt_b++; if (cnt_b >= 20) fin_b = 1'b1; end
    dd_a = ram(mode, key_a, addr_a);
    dd_b = ram(mode, key_b, addr_b);

    if (clr) begin
      launches = 0; keychg_bad = 0; byte6 = 0; reads = 0; idle_bad = 0; maxaddr = 0;
    end else begin
      if (st_c && !prev_st) launches++;
      if (key_c != prev_key && prev_st && !reset) keychg_bad++;
      if (tap_c == 4'd4) begin
        reads++;
        if (int'(addr_c) > maxaddr) maxaddr = int'(addr_c);
        if (mode == 2 && key_c < 24'd3 && addr_c == 8'd6) byte6++;
      end
      if (tap_c != 4'd0 || st_c) idle_bad++;
    end
    prev_st  = st_c;
    prev_key = key_c;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 3000 && !done_c; i++) @(negedge clk);
    chk({name, "_timeout"}, int'(done_c), 1);
  endtask

  task automatic do_reset(input int m, input logic which);
    @(negedge clk);
    reset = 1'b1; ss_a = 1'b0; ss_b = 1'b0; stuck_a = 1'b0;
    mode = m; cur = which; clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0; reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic        use_b;
    int          exp_launch;
    logic [23:0] exp_key;
    logic        exp_found;
    logic        exp_fail;
    int          exp_maxaddr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"all_a",    1, 1'b0, 1, 24'h000000, 1'b1, 1'b0, 31};
    vecs[1] = '{"byte5",    2, 1'b0, 4, 24'h000003, 1'b1, 1'b0, 31};
    vecs[2] = '{"exhaust",  3, 1'b1, 4, 24'h000003, 1'b0, 1'b1, 0};
    vecs[3] = '{"charedge", 4, 1'b0, 3, 24'h000002, 1'b1, 1'b0, 31};

    // Reset state, then idle with search_start low.
    clr = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_start", int'(start_a), 0);
    chk("rst_key",   int'(key_a), 0);
    chk("rst_addr",  int'(addr_a), 0);
    chk("rst_found", int'(found_a), 0);
    chk("rst_fail",  int'(fail_a), 0);
    chk("rst_tap",   int'(tap_a), 0);
    clr = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_activity", idle_bad, 0);
    chk("idle_key", int'(key_a), 0);
    chk("idle_done", int'(done_a), 0);

    foreach (vecs[n]) begin
      do_reset(vecs[n].mode, vecs[n].use_b);
      @(negedge clk);
      if (vecs[n].use_b) ss_b = 1'b1; else ss_a = 1'b1;
      wait_done(vecs[n].name);
      ss_a = 1'b0; ss_b = 1'b0;
      repeat (100) @(negedge clk);
      chk({vecs[n].name, "_launches"}, launches, vecs[n].exp_launch);
      chk({vecs[n].name, "_key"},      int'(key_c), int'(vecs[n].exp_key));
      chk({vecs[n].name, "_found"},    int'(found_c), int'(vecs[n].exp_found));
      chk({vecs[n].name, "_fail"},     int'(fail_c), int'(vecs[n].exp_fail));
      chk({vecs[n].name, "_done"},     int'(done_c), 1);
      chk({vecs[n].name, "_start"},    int'(st_c), 0);
      chk({vecs[n].name, "_maxaddr"},  maxaddr, vecs[n].exp_maxaddr);
      chk({vecs[n].name, "_keychg"},   keychg_bad, 0);
      chk({vecs[n].name, "_byte6"},    byte6, 0);
    end

    // Reset during WAIT_DONE with finished stuck high.
    do_reset(1, 1'b0);
    @(negedge clk);
    ss_a = 1'b1;
    for (int i = 0; i < 200 && tap_a != 4'd2; i++) @(negedge clk);
    chk("midrst_reach_wait", int'(tap_a), 2);
    reset = 1'b1; stuck_a = 1'b1; ss_a = 1'b0;
    @(posedge clk); #1;
    chk("midrst_start", int'(start_a), 0);
    chk("midrst_tap",   int'(tap_a), 0);
    chk("midrst_key",   int'(key_a), 0);
    @(negedge clk);
    reset = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_reads", reads, 0);
    chk("midrst_launch", launches, 0);
    chk("midrst_idle", int'(tap_a), 0);

    // Stale finished flag: must wait in RELEASE for the low phase.
    ss_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("stale_release", int'(tap_a), 3);
    chk("stale_reads", reads, 0);
    chk("stale_launch", launches, 1);
    stuck_a = 1'b0;
    wait_done("stale");
    chk("stale_found", int'(found_a), 1);
    chk("stale_key", int'(key_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
